alu_exec_unit: RTL

//  Registered ALU decode+execute stage with valid/ready handshakes on input and output.

---
 rtl/alu_exec_unit.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Registered RV32I ALU decode+execute stage with valid/ready on both sides.
// Define ALU_MUL_EN to add an iterative shift-add multiplier (BUSY path).
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             funct7_0,
  input  logic             op_5,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       alu_ctrl
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] C_ADD  = 4'd0;
  localparam logic [3:0] C_SUB  = 4'd1;
  localparam logic [3:0] C_AND  = 4'd2;
  localparam logic [3:0] C_OR   = 4'd3;
  localparam logic [3:0] C_XOR  = 4'd4;
  localparam logic [3:0] C_SLT  = 4'd5;
  localparam logic [3:0] C_SLTU = 4'd6;
  localparam logic [3:0] C_SLL  = 4'd7;
  localparam logic [3:0] C_SRL  = 4'd8;
  localparam logic [3:0] C_SRA  = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] C_MUL  = 4'd10;
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_e;
`endif

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic [3:0]           alu_ctrl_q, alu_ctrl_d;

  logic [3:0]           ctrl_c;
  logic [WIDTH-1:0]     exec_c;
  logic [SHAMT_W-1:0]   shamt_c;
  logic                 accept_c;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]     acc_sum_c;
`else
  logic                 unused_funct7_0;
  assign unused_funct7_0 = funct7_0;
`endif

  // Control decode from ALUOp and instruction fields
  always_comb begin
    ctrl_c = C_ADD;
    case (alu_op)
      2'b00: ctrl_c = C_ADD;
      2'b01: ctrl_c = C_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  ctrl_c = (funct7_5 & op_5) ? C_SUB : C_ADD;
          3'b001:  ctrl_c = C_SLL;
          3'b010:  ctrl_c = C_SLT;
          3'b011:  ctrl_c = C_SLTU;
          3'b100:  ctrl_c = C_XOR;
          3'b101:  ctrl_c = funct7_5 ? C_SRA : C_SRL;
          3'b110:  ctrl_c = C_OR;
          default: ctrl_c = C_AND;
        endcase
`ifdef ALU_MUL_EN
        if (op_5 && funct7_0 && (funct3 == 3'b000)) begin
          ctrl_c = C_MUL;
        end
`endif
      end
      default: ctrl_c = C_ADD;
    endcase
  end

  // Single-cycle execute; mul is handled by the iterative datapath
  always_comb begin
    shamt_c = src_b[SHAMT_W-1:0];
    exec_c  = src_a + src_b;
    case (ctrl_c)
      C_SUB:   exec_c = src_a - src_b;
      C_AND:   exec_c = src_a & src_b;
      C_OR:    exec_c = src_a | src_b;
      C_XOR:   exec_c = src_a ^ src_b;
      C_SLT:   exec_c = WIDTH'($signed(src_a) < $signed(src_b));
      C_SLTU:  exec_c = WIDTH'(src_a < src_b);
      C_SLL:   exec_c = src_a << shamt_c;
      C_SRL:   exec_c = src_a >> shamt_c;
      C_SRA:   exec_c = WIDTH'($signed(src_a) >>> shamt_c);
      default: exec_c = src_a + src_b;
    endcase
  end

`ifdef ALU_MUL_EN
  assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Handshake FSM: next state, held outputs and multiplier stepping
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    alu_ctrl_d = alu_ctrl_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
`ifdef ALU_MUL_EN
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: in_ready = 1'b1;
`ifdef ALU_MUL_EN
      S_BUSY: begin
        in_ready = 1'b0;
        acc_d    = acc_sum_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(WIDTH - 1)) begin
          result_d = acc_sum_c;
          zero_d   = (acc_sum_c == '0);
          state_d  = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    accept_c = in_valid & in_ready;

    if (accept_c) begin
      alu_ctrl_d = ctrl_c;
`ifdef ALU_MUL_EN
      if (ctrl_c == C_MUL) begin
        acc_d    = '0;
        mcand_d  = src_a;
        mplier_d = src_b;
        cnt_d    = '0;
        state_d  = S_BUSY;
      end else begin
        result_d = exec_c;
        zero_d   = (exec_c == '0);
        state_d  = S_HOLD;
      end
`else
      result_d = exec_c;
      zero_d   = (exec_c == '0);
      state_d  = S_HOLD;
`endif
    end
  end

  // State and result registers; reset discards any in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b1;
      alu_ctrl_q <= C_ADD;
`ifdef ALU_MUL_EN
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      alu_ctrl_q <= alu_ctrl_d;
`ifdef ALU_MUL_EN
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign alu_ctrl = alu_ctrl_q;

endmodule
